// File: rtl/syscall_pkg.sv
// Shared service codes, console constants and sequencer states for the syscall controller.
package syscall_pkg;

  localparam logic [31:0] SYS_PRINT_INT = 32'd1;
  localparam logic [31:0] SYS_PRINT_STR = 32'd4;
  localparam logic [31:0] SYS_EXIT      = 32'd10;

  localparam logic [7:0]  CHAR_NL       = 8'h0A;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INT_OUT   = 3'd1,
    STR_FETCH = 3'd2,
    STR_CHAR  = 3'd3,
    STR_NL    = 3'd4,
    HALT      = 3'd5
  } sys_state_t;

  // True for the service codes this sequencer acts on.
  function automatic logic is_service(input logic [31:0] code);
    return (code == SYS_PRINT_INT) || (code == SYS_PRINT_STR) || (code == SYS_EXIT);
  endfunction

endpackage

// File: rtl/syscall_byte_sel.sv
// Little-endian byte lane extraction from a fetched string word.
module syscall_byte_sel
  import syscall_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_bidx,
  output logic [7:0]  o_byte,
  output logic        o_zero
);

  // Lane 0 is the lowest-addressed character.
  always_comb begin
    o_byte = i_word[{i_bidx, 3'b000} +: 8];
    o_zero = (o_byte == 8'h00);
  end

endmodule

// File: rtl/syscall_ctrl.sv
// Multi-cycle syscall sequencer: print int, print string, exit; owns the memory read mux.
module syscall_ctrl
  import syscall_pkg::*;
#(
  parameter int unsigned ADDR_W    = 30,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sys,
  input  logic [31:0]       regv,
  input  logic [31:0]       rega,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              stall,
  output logic              char_valid,
  output logic [7:0]        char_data,
  input  logic              char_ready,
  output logic              int_valid,
  output logic [31:0]       int_data,
  input  logic              int_ready,
  output logic              halt,
  output logic              overrun
);

  localparam int unsigned WCNT_W = $clog2(MAX_WORDS + 1);

  sys_state_t        r_state, w_state_nx;
  logic              r_sys_q;
  logic [31:0]       r_rega, w_rega_nx;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nx;
  logic [31:0]       r_word, w_word_nx;
  logic [1:0]        r_bidx, w_bidx_nx;
  logic [WCNT_W-1:0] r_wcnt, w_wcnt_nx;
  logic              r_overrun, w_overrun_nx;
  logic              w_sys_rise;
  logic [7:0]        w_byte;
  logic              w_byte_zero;

  assign w_sys_rise = sys & ~r_sys_q;
  assign overrun    = r_overrun;

  syscall_byte_sel u_byte_sel (
    .i_word (r_word),
    .i_bidx (r_bidx),
    .o_byte (w_byte),
    .o_zero (w_byte_zero)
  );

  // State and datapath registers; reset returns to IDLE from any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_sys_q   <= 1'b0;
      r_rega    <= '0;
      r_ptr     <= '0;
      r_word    <= '0;
      r_bidx    <= '0;
      r_wcnt    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_sys_q   <= sys;
      r_rega    <= w_rega_nx;
      r_ptr     <= w_ptr_nx;
      r_word    <= w_word_nx;
      r_bidx    <= w_bidx_nx;
      r_wcnt    <= w_wcnt_nx;
      r_overrun <= w_overrun_nx;
    end
  end

  // Next-state, datapath updates and console/memory outputs.
  always_comb begin
    w_state_nx   = r_state;
    w_rega_nx    = r_rega;
    w_ptr_nx     = r_ptr;
    w_word_nx    = r_word;
    w_bidx_nx    = r_bidx;
    w_wcnt_nx    = r_wcnt;
    w_overrun_nx = r_overrun;
    mem_addr     = fetch_pc;
    stall        = (r_state != IDLE);
    char_valid   = 1'b0;
    char_data    = 8'h00;
    int_valid    = 1'b0;
    int_data     = 32'h0;
    halt         = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_sys_rise && is_service(regv)) begin
          stall     = 1'b1;
          w_rega_nx = rega;
          if (regv == SYS_PRINT_INT) begin
            w_state_nx = INT_OUT;
          end else if (regv == SYS_PRINT_STR) begin
            w_ptr_nx     = rega[ADDR_W-1:0];
            w_wcnt_nx    = '0;
            w_overrun_nx = 1'b0;
            w_state_nx   = STR_FETCH;
          end else begin
            w_state_nx = HALT;
          end
        end
      end
      INT_OUT: begin
        int_valid = 1'b1;
        int_data  = r_rega;
        if (int_ready) w_state_nx = IDLE;
      end
      STR_FETCH: begin
        mem_addr   = r_ptr;
        w_word_nx  = mem_rdata;
        w_bidx_nx  = 2'd0;
        w_wcnt_nx  = r_wcnt + WCNT_W'(1);
        w_state_nx = (mem_rdata == 32'h0) ? STR_NL : STR_CHAR;
      end
      STR_CHAR: begin
        if (w_byte_zero) begin
          w_state_nx = STR_NL;
        end else begin
          char_valid = 1'b1;
          char_data  = w_byte;
          if (char_ready) begin
            if (r_bidx != 2'd3) begin
              w_bidx_nx = r_bidx + 2'd1;
            end else if (r_wcnt == WCNT_W'(MAX_WORDS)) begin
              w_overrun_nx = 1'b1;
              w_state_nx   = STR_NL;
            end else begin
              w_ptr_nx   = r_ptr + ADDR_W'(1);
              w_state_nx = STR_FETCH;
            end
          end
        end
      end
      STR_NL: begin
        char_valid = 1'b1;
        char_data  = CHAR_NL;
        if (char_ready) w_state_nx = IDLE;
      end
      HALT: begin
        halt = 1'b1;
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_syscall_ctrl.sv
// Scoreboard bench for syscall_ctrl: int print, strings, backpressure, overrun, exit, reset.
module tb_syscall_ctrl;

  localparam int unsigned ADDR_W = 30;
  localparam logic [29:0] BASE    = 30'h00100024;
  localparam logic [29:0] PC      = 30'h00000155;
  localparam logic [29:0] NO_ADDR = 30'h3FFFFFFF;

  logic              clk;
  logic              rst_n;
  logic              sys;
  logic [31:0]       regv;
  logic [31:0]       rega;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              stall;
  logic              char_valid;
  logic [7:0]        char_data;
  logic              char_ready;
  logic              int_valid;
  logic [31:0]       int_data;
  logic              int_ready;
  logic              halt;
  logic              overrun;

  logic [31:0] mem_arr [8];
  logic [7:0]  exp_q[$];
  logic [31:0] exp_int_q[$];

  int checks;
  int errors;

  syscall_ctrl #(.ADDR_W(ADDR_W), .MAX_WORDS(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sys        (sys),
    .regv       (regv),
    .rega       (rega),
    .fetch_pc   (fetch_pc),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .stall      (stall),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .int_valid  (int_valid),
    .int_data   (int_data),
    .int_ready  (int_ready),
    .halt       (halt),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational memory: small window at BASE, zero elsewhere.
  always_comb begin
    mem_rdata = 32'h0;
    for (int i = 0; i < 8; i++)
      if (mem_addr == BASE + 30'(i)) mem_rdata = mem_arr[i];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sys = 1'b0; regv = 32'h0; rega = 32'h0;
    fetch_pc = PC; char_ready = 1'b0; int_ready = 1'b0;
    #2;
    checks++;
    if (stall !== 1'b0 || char_valid !== 1'b0 || char_data !== 8'h00 || int_valid !== 1'b0 ||
        int_data !== 32'h0 || halt !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got stall=%b cv=%b cd=%h iv=%b id=%h halt=%b ovr=%b expected all 0",
               stall, char_valid, char_data, int_valid, int_data, halt, overrun);
    end
    checks++;
    if (mem_addr !== PC) begin
      errors++;
      $display("FAIL reset_mem_addr: got %h expected %h", mem_addr, PC);
    end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_int_print(input logic [31:0] val);
    int  stall_cnt;
    int  ival_cnt;
    bit  addr_bad;
    logic [31:0] e;
    stall_cnt = 0; ival_cnt = 0; addr_bad = 1'b0;
    exp_int_q.push_back(val);
    regv = 32'd1; rega = val; sys = 1'b1; int_ready = 1'b1;
    #1;
    if (stall === 1'b1) stall_cnt++;
    if (mem_addr !== fetch_pc) addr_bad = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      sys = 1'b0;
      #1;
      if (stall === 1'b1) stall_cnt++;
      if (mem_addr !== fetch_pc) addr_bad = 1'b1;
      if (int_valid === 1'b1) begin
        ival_cnt++;
        if (int_ready) begin
          checks++;
          if (exp_int_q.size() == 0) begin
            errors++;
            $display("FAIL int_extra: got %h expected none", int_data);
          end else begin
            e = exp_int_q.pop_front();
            if (int_data !== e) begin
              errors++;
              $display("FAIL int_data: got %h expected %h", int_data, e);
            end
          end
        end
      end
    end
    checks++;
    if (stall_cnt != 2) begin
      errors++;
      $display("FAIL int_stall_cycles: got %0d expected 2", stall_cnt);
    end
    checks++;
    if (ival_cnt != 1 || exp_int_q.size() != 0) begin
      errors++;
      $display("FAIL int_valid_cycles: got %0d (pending %0d) expected 1 (pending 0)", ival_cnt, exp_int_q.size());
    end
    checks++;
    if (addr_bad) begin
      errors++;
      $display("FAIL int_mem_addr: got deviation from fetch_pc expected none");
    end
  endtask

  // Drives a service-4 call and consumes console bytes against exp_q.
  task automatic run_string(input logic [29:0] addr, input int rdy_mode,
                            input logic exp_ovr, input logic [29:0] forbidden);
    bit   done;
    bit   bad_addr;
    bit   prev_hold;
    logic [7:0] prev_data;
    logic [7:0] e;
    done = 1'b0; bad_addr = 1'b0; prev_hold = 1'b0; prev_data = 8'h00;
    regv = 32'd4; rega = {2'b00, addr}; sys = 1'b1; char_ready = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL str_trigger_stall: got %b expected 1", stall);
    end
    for (int c = 0; c < 200; c++) begin
      step();
      sys = 1'b0;
      char_ready = (rdy_mode == 0) ? 1'b1 : ((c % 3) == 0);
      #1;
      if (prev_hold) begin
        checks++;
        if (char_valid !== 1'b1 || char_data !== prev_data) begin
          errors++;
          $display("FAIL str_hold_stable: got valid=%b data=%h expected valid=1 data=%h",
                   char_valid, char_data, prev_data);
        end
      end
      if (mem_addr === forbidden) bad_addr = 1'b1;
      if (char_valid === 1'b1 && char_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL str_extra_byte: got %h expected none", char_data);
        end else begin
          e = exp_q.pop_front();
          if (char_data !== e) begin
            errors++;
            $display("FAIL str_byte: got %h expected %h", char_data, e);
          end
        end
      end
      prev_hold = (char_valid === 1'b1) && !char_ready;
      prev_data = char_data;
      if (stall === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done || exp_q.size() != 0) begin
      errors++;
      $display("FAIL str_complete: got done=%b pending=%0d expected done=1 pending=0", done, exp_q.size());
    end
    checks++;
    if (overrun !== exp_ovr) begin
      errors++;
      $display("FAIL str_overrun: got %b expected %b", overrun, exp_ovr);
    end
    checks++;
    if (bad_addr || mem_addr !== fetch_pc) begin
      errors++;
      $display("FAIL str_mem_addr: got forbidden_hit=%b addr=%h expected 0 and %h", bad_addr, mem_addr, fetch_pc);
    end
    exp_q.delete();
    char_ready = 1'b0;
  endtask

  task automatic push_hello();
    exp_q.push_back(8'h48); exp_q.push_back(8'h65); exp_q.push_back(8'h6C);
    exp_q.push_back(8'h6C); exp_q.push_back(8'h6F); exp_q.push_back(8'h21);
    exp_q.push_back(8'h0A);
  endtask

  task automatic test_string();
    push_hello();
    run_string(BASE, 0, 1'b0, NO_ADDR);
    step();
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h41 + 8'(i));
    exp_q.push_back(8'h0A);
    run_string(BASE + 30'd4, 0, 1'b1, BASE + 30'd6);
    step();
  endtask

  task automatic test_backpressure();
    push_hello();
    run_string(BASE, 1, 1'b0, NO_ADDR);
    step();
  endtask

  task automatic test_back_to_back();
    test_int_print(32'h7FFF0001);
    step();
    push_hello();
    run_string(BASE, 0, 1'b0, NO_ADDR);
    step();
  endtask

  task automatic test_exit_held_sys();
    bit bad;
    bad = 1'b0;
    regv = 32'd10; sys = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL exit_trigger_stall: got %b expected 1", stall);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      if (halt !== 1'b1 || stall !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL exit_sticky: got halt=%b stall=%b expected 1 1", halt, stall);
    end
    regv = 32'd1;
    bad = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (int_valid !== 1'b0 || halt !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL exit_no_retrigger: got int_valid=%b halt=%b expected 0 1", int_valid, halt);
    end
    sys = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (halt !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL exit_reset: got halt=%b stall=%b expected 0 0", halt, stall);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_string();
    bit seen;
    seen = 1'b0;
    regv = 32'd4; rega = {2'b00, BASE}; sys = 1'b1; char_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      sys = 1'b0;
      if (char_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL midstr_reach_char: got no char_valid expected char_valid within 10 cycles");
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (char_valid !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL midstr_async_reset: got cv=%b stall=%b expected 0 0", char_valid, stall);
    end
    step();
    #2;
    rst_n = 1'b1;
    step();
    checks++;
    if (mem_addr !== fetch_pc || stall !== 1'b0 || char_valid !== 1'b0) begin
      errors++;
      $display("FAIL midstr_idle: got addr=%h stall=%b cv=%b expected %h 0 0", mem_addr, stall, char_valid, fetch_pc);
    end
    regv = 32'd7; rega = 32'h1234; sys = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL unknown_code_trigger: got stall=%b expected 0", stall);
    end
    step();
    sys = 1'b0;
    step();
    checks++;
    if (stall !== 1'b0 || int_valid !== 1'b0 || char_valid !== 1'b0 || halt !== 1'b0) begin
      errors++;
      $display("FAIL unknown_code_idle: got stall=%b iv=%b cv=%b halt=%b expected 0 0 0 0",
               stall, int_valid, char_valid, halt);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 8; i++) mem_arr[i] = 32'h0;
    mem_arr[0] = 32'h6C6C6548;
    mem_arr[1] = 32'h0000216F;
    mem_arr[4] = 32'h44434241;
    mem_arr[5] = 32'h48474645;
    mem_arr[6] = 32'h4C4B4A49;
    test_reset();
    test_int_print(32'hFFFFFFFB);
    step();
    test_string();
    test_overrun();
    test_backpressure();
    test_back_to_back();
    test_exit_held_sys();
    test_reset_mid_string();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
